seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier with controller; next generation of the team's fixed 32-bit multiplier.
- Generic operand width, per-transaction signed/unsigned mode and a zero-operand fast path.
- Result register is held from one completion until the next completion or reset.
- Sits between a requesting master (valid/idle handshake) and consumers of oResult (done/acknowledge handshake).

Parameters:
- DATA_SIZE, 32, operand width N (legal range 2..64).
- COUNTER_SIZE, derived localparam = $clog2(DATA_SIZE), iteration counter width. Not overridable.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iData_A  in  DATA_SIZE  multiplicand; sampled only at the accept edge.
- iData_B  in  DATA_SIZE  multiplier; sampled only at the accept edge.
- iSigned  in  1  1 = two's-complement operands, 0 = unsigned; sampled at the accept edge.
- iValid_Data  in  1  request; accepted only when oIdle=1.
- iAcknoledged  in  1  consumer has taken the result; honoured only when oDone=1.
- oIdle  out  1  block can accept a request (state IDLE).
- oDone  out  1  oResult valid (state DONE).
- oResult  out  2*DATA_SIZE  registered product.

Behaviour:
- States (2-bit): IDLE, MULT, DONE. Outputs are a function of state: IDLE gives oIdle=1; DONE gives oDone=1; otherwise both are 0.
- Reset, applied at any time including mid-MULT or in DONE:
  - next state IDLE; accumulator, counter, sign flag and oResult cleared to 0.
  - In the cycle after the reset edge: oIdle=1, oDone=0, oResult=0.
- IDLE:
  - Accept edge = iValid_Data=1 while in IDLE.
  - At the accept edge, latch |A| and |B| (magnitudes if iSigned=1, raw otherwise) and the sign flag neg = iSigned & (A[N-1] ^ B[N-1]). Clear the accumulator and counter.
  - If A==0 or B==0: go directly to DONE with oResult=0 (latency 1). Otherwise go to MULT.
- MULT:
  - One shift-add iteration per cycle, LSB-first on the multiplier: if multiplier LSB=1, add the multiplicand to the accumulator's upper half; then shift right one bit (carry included).
  - Exactly DATA_SIZE iterations, counter values 0..DATA_SIZE-1.
  - On the edge where counter==DATA_SIZE-1, load oResult = neg ? -(product) : product (2N-bit two's complement) and go to DONE.
  - Latency from accept edge to first oDone=1 cycle is DATA_SIZE+1 cycles.
  - iValid_Data and iAcknoledged are ignored in MULT.
- DONE:
  - oResult stable. iAcknoledged=1 at an edge returns to IDLE; otherwise stay in DONE.
  - iValid_Data is ignored in DONE; a request asserted during DONE is only taken at an edge in IDLE (earliest one cycle after ack).
- oResult is never modified in IDLE: it holds the last result (or 0 after reset).
- Width rules:
  - Magnitude of -2^(N-1) is 2^(N-1), which fits N unsigned bits.
  - Maximum product magnitude is (2^N-1)^2 unsigned or 2^(2N-2) signed, so 2N bits never overflow.
  - iSigned=0 with MSB set is treated as a large unsigned value.
- Simultaneous iValid_Data and iAcknoledged in DONE: ack is taken, the request is dropped; the master must re-present it in IDLE.
- Unreachable 2-bit state encoding: next state IDLE, outputs as IDLE.

Decomposition:
- Shared header holds the state encodings STATE_IDLE=2'd0, STATE_MULT=2'd1, STATE_DONE=2'd2; 2'd3 is reserved.
- One sub-module, seq_mult_datapath:
  - Holds the operand, accumulator and sign registers plus the add/shift logic.
  - Controls: load, step, commit.
  - Outputs: product, zero_operand.
- The controller FSM and counter live in seq_multiplier.

Test Plan:
- DATA_SIZE=8, iSigned=0, A=8'd255, B=8'd255 -> oDone rises 9 cycles after accept; oResult=16'd65025; stays stable until ack, then oIdle=1.
- DATA_SIZE=8, iSigned=1, A=8'h80 (-128), B=8'h80 -> oResult=16'h4000 (16384); A=8'h80, B=8'h01 -> oResult=16'hFF80 (-128).
- DATA_SIZE=32, iSigned=1, A=-3, B=7 -> oResult=64'hFFFF_FFFF_FFFF_FFEB (-21) after 33 cycles; the same operands with iSigned=0 give 64'h0000_0006_FFFF_FFEB.
- Zero fast path: A=0, B=12345 -> oDone=1 one cycle after accept with oResult=0; iAcknoledged held 0 for 10 cycles -> stays in DONE with oResult unchanged.
- Reset mid-operation: accept A=5, B=6, assert Reset at counter=3 -> next cycle oIdle=1, oDone=0, oResult=0; a new request A=2, B=3 then gives oResult=6.
- Handshake robustness: iValid_Data pulses during MULT and iAcknoledged pulses during MULT/IDLE -> no state change. Valid+ack together in DONE -> returns to IDLE with no new multiply started.

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared state encodings for the sequential multiplier
package seq_multiplier_pkg;

    // 2'd3 is reserved and recovers to IDLE
    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_MULT = 2'd1,
        STATE_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult_datapath.sv
// rtl/seq_mult_datapath.sv - operand, accumulator, sign and result registers with shift-add step
module seq_mult_datapath
    import seq_multiplier_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     load,
    input  logic                     step,
    input  logic                     commit,
    input  logic                     sign_mode,
    input  logic [DATA_SIZE-1:0]     data_a,
    input  logic [DATA_SIZE-1:0]     data_b,
    output logic [2*DATA_SIZE-1:0]   product,
    output logic                     zero_operand
);

    localparam int N = DATA_SIZE;

    logic [N-1:0]   mcand_q;
    logic [2*N-1:0] acc_q;
    logic           neg_q;
    logic [2*N-1:0] result_q;

    logic [N-1:0]   mag_a;
    logic [N-1:0]   mag_b;
    logic [N:0]     upper_sum;
    logic [2*N-1:0] acc_step;
    logic [2*N-1:0] signed_step;

    // Lower half of the accumulator doubles as the multiplier shift register.
    always_comb begin
        mag_a        = (sign_mode && data_a[N-1]) ? -data_a : data_a;
        mag_b        = (sign_mode && data_b[N-1]) ? -data_b : data_b;
        zero_operand = (data_a == '0) || (data_b == '0);
        upper_sum    = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step     = {upper_sum, acc_q[N-1:1]};
        signed_step  = neg_q ? -acc_step : acc_step;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else if (load) begin
            mcand_q <= mag_a;
            acc_q   <= {{N{1'b0}}, mag_b};
            neg_q   <= sign_mode & (data_a[N-1] ^ data_b[N-1]);
            if (commit) begin
                result_q <= '0;
            end
        end else if (step) begin
            acc_q <= acc_step;
            if (commit) begin
                result_q <= signed_step;
            end
        end
    end

    assign product = result_q;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - controller FSM and iteration counter for the shift-add multiplier
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int DATA_SIZE = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [DATA_SIZE-1:0]     iData_A,
    input  logic [DATA_SIZE-1:0]     iData_B,
    input  logic                     iSigned,
    input  logic                     iValid_Data,
    input  logic                     iAcknoledged,
    output logic                     oIdle,
    output logic                     oDone,
    output logic [2*DATA_SIZE-1:0]   oResult
);

    localparam int COUNTER_SIZE = $clog2(DATA_SIZE);
    localparam logic [COUNTER_SIZE-1:0] LAST_COUNT = COUNTER_SIZE'(DATA_SIZE - 1);

    state_e                  state_q;
    logic [COUNTER_SIZE-1:0] count_q;
    logic                    idle_q;
    logic                    done_q;

    logic accept;
    logic last_iter;
    logic zero_operand;
    logic dp_step;
    logic dp_commit;

    assign accept    = (state_q == STATE_IDLE) && iValid_Data;
    assign last_iter = (state_q == STATE_MULT) && (count_q == LAST_COUNT);
    assign dp_step   = (state_q == STATE_MULT);
    assign dp_commit = (accept && zero_operand) || last_iter;

    seq_mult_datapath #(
        .DATA_SIZE(DATA_SIZE)
    ) u_datapath (
        .Clock        (Clock),
        .Reset        (Reset),
        .load         (accept),
        .step         (dp_step),
        .commit       (dp_commit),
        .sign_mode    (iSigned),
        .data_a       (iData_A),
        .data_b       (iData_B),
        .product      (oResult),
        .zero_operand (zero_operand)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= STATE_IDLE;
            count_q <= '0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (iValid_Data) begin
                        count_q <= '0;
                        idle_q  <= 1'b0;
                        if (zero_operand) begin
                            state_q <= STATE_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= STATE_MULT;
                        end
                    end
                end
                STATE_MULT: begin
                    if (count_q == LAST_COUNT) begin
                        state_q <= STATE_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        count_q <= count_q + COUNTER_SIZE'(1);
                    end
                end
                STATE_DONE: begin
                    // A request coinciding with the ack is dropped, not queued.
                    if (iAcknoledged) begin
                        state_q <= STATE_IDLE;
                        idle_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= STATE_IDLE;
                    count_q <= '0;
                    idle_q  <= 1'b1;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oIdle = idle_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed scoreboard bench for 8-bit and 32-bit multiplier instances
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b1, v8 = 1'b0, ack8 = 1'b0, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        idle8, done8;
    logic [15:0] res8;

    logic        rst32 = 1'b1, v32 = 1'b0, ack32 = 1'b0, s32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        idle32, done32;
    logic [63:0] res32;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    seq_multiplier #(.DATA_SIZE(8)) dut8 (
        .Clock(clk), .Reset(rst8), .iData_A(a8), .iData_B(b8), .iSigned(s8),
        .iValid_Data(v8), .iAcknoledged(ack8), .oIdle(idle8), .oDone(done8), .oResult(res8)
    );

    seq_multiplier #(.DATA_SIZE(32)) dut32 (
        .Clock(clk), .Reset(rst32), .iData_A(a32), .iData_B(b32), .iSigned(s32),
        .iValid_Data(v32), .iAcknoledged(ack32), .oIdle(idle32), .oDone(done32), .oResult(res32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: sign/zero extend to 64 bits, multiply, keep the low 2w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        logic [63:0] av, bv, p;
        if (w == 8) begin
            av = s ? {{56{a[7]}}, a[7:0]} : {56'd0, a[7:0]};
            bv = s ? {{56{b[7]}}, b[7:0]} : {56'd0, b[7:0]};
        end else begin
            av = s ? {{32{a[31]}}, a} : {32'd0, a};
            bv = s ? {{32{b[31]}}, b} : {32'd0, b};
        end
        p = av * bv;
        return (w == 8) ? {48'd0, p[15:0]} : p;
    endfunction

    function automatic logic idle_of(input int w);
        return (w == 8) ? idle8 : idle32;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done32;
    endfunction

    function automatic logic [63:0] res_of(input int w);
        return (w == 8) ? {48'd0, res8} : res32;
    endfunction

    task automatic drive(input int w, input logic v, input logic k, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
        if (w == 8) begin
            v8 = v; ack8 = k; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
        end else begin
            v32 = v; ack32 = k; a32 = a; b32 = b; s32 = s;
        end
    endtask

    task automatic start(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        drive(w, 1'b1, 1'b0, a, b, s);
        exp_q.push_back(model(w, a, b, s));
        @(posedge clk);
        #1;
        drive(w, 1'b0, 1'b0, a, b, s);
    endtask

    task automatic finish_op(input int w, input string tag, input int lat0, input int exp_lat);
        int lat;
        logic [63:0] e;
        lat = lat0;
        while (!done_of(w) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        e = exp_q.pop_front();
        check({tag, "_res"}, res_of(w), e);
    endtask

    task automatic ack(input int w, input string tag);
        @(negedge clk);
        drive(w, 1'b0, 1'b1, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 1'b0, '0, '0, 1'b0);
        check({tag, "_ack_idle"}, 64'(idle_of(w)), 64'd1);
        check({tag, "_ack_done"}, 64'(done_of(w)), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] hold;
        repeat (2) @(posedge clk);
        #1;
        check("rst8_idle", 64'(idle8), 64'd1);
        check("rst8_done", 64'(done8), 64'd0);
        check("rst8_res", {48'd0, res8}, 64'd0);
        check("rst32_idle", 64'(idle32), 64'd1);
        check("rst32_res", res32, 64'd0);
        @(negedge clk);
        rst8 = 1'b0;
        rst32 = 1'b0;

        // 255*255 unsigned, then hold until ack
        start(8, 32'd255, 32'd255, 1'b0);
        finish_op(8, "u255", 1, 9);
        check("u255_abs", {48'd0, res8}, 64'd65025);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("u255_hold_done", 64'(done8), 64'd1);
            check("u255_hold_res", {48'd0, res8}, 64'd65025);
        end
        ack(8, "u255");
        check("u255_after_ack_res", {48'd0, res8}, 64'd65025);

        start(8, 32'h80, 32'h80, 1'b1);
        finish_op(8, "s80x80", 1, 9);
        check("s80x80_abs", {48'd0, res8}, 64'h4000);
        ack(8, "s80x80");
        start(8, 32'h80, 32'h01, 1'b1);
        finish_op(8, "s80x01", 1, 9);
        check("s80x01_abs", {48'd0, res8}, 64'hFF80);
        ack(8, "s80x01");

        start(32, 32'hFFFF_FFFD, 32'd7, 1'b1);
        finish_op(32, "s32", 1, 33);
        check("s32_abs", res32, 64'hFFFF_FFFF_FFFF_FFEB);
        ack(32, "s32");
        start(32, 32'hFFFF_FFFD, 32'd7, 1'b0);
        finish_op(32, "u32", 1, 33);
        check("u32_abs", res32, 64'h0000_0006_FFFF_FFEB);
        ack(32, "u32");

        // zero fast path holds in DONE without ack
        start(32, 32'd0, 32'd12345, 1'b1);
        finish_op(32, "zero", 1, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("zero_hold_done", 64'(done32), 64'd1);
            check("zero_hold_res", res32, 64'd0);
        end
        ack(32, "zero");

        // reset while the counter is at 3
        start(8, 32'd5, 32'd6, 1'b0);
        hold = exp_q.pop_front();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_idle", 64'(idle8), 64'd1);
        check("midrst_done", 64'(done8), 64'd0);
        check("midrst_res", {48'd0, res8}, 64'd0);
        @(negedge clk);
        rst8 = 1'b0;
        start(8, 32'd2, 32'd3, 1'b0);
        finish_op(8, "after_rst", 1, 9);
        ack(8, "after_rst");

        // stray valid/ack pulses during MULT must not disturb it
        start(8, 32'd7, 32'd9, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(8, 1'b1, 1'b1, 32'd1, 32'd1, 1'b0);
            @(posedge clk);
            #1;
            drive(8, 1'b0, 1'b0, 32'd7, 32'd9, 1'b0);
            check("mult_pulse_idle", 64'(idle8), 64'd0);
            check("mult_pulse_done", 64'(done8), 64'd0);
        end
        finish_op(8, "pulsed", 4, 9);
        ack(8, "pulsed");
        ack(8, "idle_ack");
        check("idle_ack_res", {48'd0, res8}, 64'd63);

        // valid and ack together in DONE: back to IDLE, request dropped
        start(8, 32'd0, 32'd5, 1'b0);
        finish_op(8, "zero8", 1, 1);
        @(negedge clk);
        drive(8, 1'b1, 1'b1, 32'd3, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        drive(8, 1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
        check("va_idle", 64'(idle8), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("va_still_idle", 64'(idle8), 64'd1);
        check("va_no_done", 64'(done8), 64'd0);
        check("va_res", {48'd0, res8}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
